// File: rtl/mcu_state_sequencer.sv
// -----------------------------------------------------------------------------
// mcu_state_sequencer
//
// Owns the shared memory bus schedule of the MCU. It sequences boot, free
// running, pause (JTAG or software break), resume and single-step. It tells the
// memory-bus controller mux who is master:
//    isBooted = 0          -> Boot Block
//    isBooted = 1, isPaused = 0 -> Processor Core
//    isBooted = 1, isPaused = 1 -> JTAG Port
// Before the JTAG port is handed the bus, the core is stopped and given up to
// DRAIN_MAX cycles to report procHalted (no memory traffic in flight).
//
// Parameters
//    DRAIN_MAX      maximum number of DRAIN cycles before a forced pause (1..15)
//
// Ports
//    clk            system clock, rising edge
//    rst            synchronous active-high reset
//    bootDone       Boot Block finished copying the SRAM image (level)
//    procHalted     core has no fetch or memory access in flight (level)
//    procInstrDone  core retired one instruction (pulse)
//    swBreak        core executed a break instruction (pulse)
//    jtagPauseReq   JTAG requests / holds pause (level)
//    jtagRunReq     JTAG resume free running (pulse)
//    jtagStepReq    JTAG execute exactly one instruction (pulse)
//    bootStart      one-cycle pulse after reset release, starts the Boot Block
//    isBooted       bus controller select, 0 only while booting
//    isPaused       bus controller select, 1 hands the bus to JTAG
//    procRun        core may fetch and execute
//    drainFault     sticky: the last drain timed out without procHalted
//    seqState       current state code, for debug and JTAG readback
// -----------------------------------------------------------------------------
module mcu_state_sequencer #(
    parameter int DRAIN_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bootDone,
    input  logic       procHalted,
    input  logic       procInstrDone,
    input  logic       swBreak,
    input  logic       jtagPauseReq,
    input  logic       jtagRunReq,
    input  logic       jtagStepReq,
    output logic       bootStart,
    output logic       isBooted,
    output logic       isPaused,
    output logic       procRun,
    output logic       drainFault,
    output logic [2:0] seqState
);

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_PAUSED = 3'd3,
        ST_STEP   = 3'd4
    } seqState_e;

    localparam logic [3:0] DRAIN_MAX_C = 4'(DRAIN_MAX);

    seqState_e  state_q, state_d;
    logic [3:0] drainCnt_q, drainCnt_d;
    logic       drainFault_q, drainFault_d;
    logic       bootIssued_q;
    logic       bootStart_q;
    logic       isBooted_q;
    logic       isPaused_q;
    logic       procRun_q;
    logic       drainTimeout;

    // The counter holds the number of DRAIN cycles already completed, so the
    // cycle in which the incremented value reaches DRAIN_MAX is the last one.
    // That gives exactly DRAIN_MAX cycles in DRAIN before a forced pause.
    assign drainTimeout = ((drainCnt_q + 4'd1) == DRAIN_MAX_C);

    // Next-state logic. The drain counter is zero outside DRAIN, which makes
    // every entry into DRAIN start from a cleared count. drainFault is set only
    // by a timeout and cleared whenever PAUSED is left.
    always_comb begin
        state_d      = state_q;
        drainCnt_d   = 4'd0;
        drainFault_d = drainFault_q;

        case (state_q)
            ST_BOOT: begin
                if (bootDone) begin
                    state_d = jtagPauseReq ? ST_PAUSED : ST_RUN;
                end
            end

            ST_RUN: begin
                if (jtagPauseReq || swBreak) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                drainCnt_d = drainCnt_q + 4'd1;
                // A core that halts on the timeout cycle is a clean drain.
                if (procHalted) begin
                    state_d = ST_PAUSED;
                end else if (drainTimeout) begin
                    state_d      = ST_PAUSED;
                    drainFault_d = 1'b1;
                end
            end

            ST_PAUSED: begin
                if (jtagStepReq) begin
                    state_d      = ST_STEP;
                    drainFault_d = 1'b0;
                end else if (jtagRunReq && !jtagPauseReq) begin
                    state_d      = ST_RUN;
                    drainFault_d = 1'b0;
                end
            end

            ST_STEP: begin
                // Pause and break are not watched here; the step ends anyway.
                if (procInstrDone) begin
                    state_d = ST_DRAIN;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, counter and output registers. Bus-select outputs are decoded from
    // the next state and registered so they change together with seqState and
    // never glitch. bootStart fires on the first edge after reset release only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            drainCnt_q   <= 4'd0;
            drainFault_q <= 1'b0;
            bootIssued_q <= 1'b0;
            bootStart_q  <= 1'b0;
            isBooted_q   <= 1'b0;
            isPaused_q   <= 1'b0;
            procRun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            drainCnt_q   <= drainCnt_d;
            drainFault_q <= drainFault_d;
            bootIssued_q <= 1'b1;
            bootStart_q  <= !bootIssued_q;
            isBooted_q   <= (state_d != ST_BOOT);
            isPaused_q   <= (state_d == ST_PAUSED);
            procRun_q    <= (state_d == ST_RUN) || (state_d == ST_STEP);
        end
    end

    assign bootStart  = bootStart_q;
    assign isBooted   = isBooted_q;
    assign isPaused   = isPaused_q;
    assign procRun    = procRun_q;
    assign drainFault = drainFault_q;
    assign seqState   = state_q;

endmodule
